// File: rtl/async_sram_responder_if.sv
// Control, address and status bundle for the async SRAM responder.
// The data bus stays a plain inout port on the responder itself.
interface async_sram_responder_if;
  logic [22:0] MemAdr;
  logic        RamCS;
  logic        MemOE;
  logic        MemWR;
  logic        RamLB;
  logic        RamUB;
  logic        RamAdv;
  logic        RamClk;
  logic        busy;
  logic        rd_done;
  logic        wr_done;
  logic        proto_err;

  modport master (
    output MemAdr, RamCS, MemOE, MemWR,
    output RamLB, RamUB, RamAdv, RamClk,
    input  busy, rd_done, wr_done, proto_err
  );

  modport slave (
    input  MemAdr, RamCS, MemOE, MemWR,
    input  RamLB, RamUB, RamAdv, RamClk,
    output busy, rd_done, wr_done, proto_err
  );
endinterface

// File: rtl/async_sram_responder.sv
// Behavioural responder for an async-mode cellular RAM: registered
// strobes, latency counters, byte-lane reads and one commit per write.
module async_sram_responder #(
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 4,
  parameter int WR_LAT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  async_sram_responder_if.slave bus,
  inout  wire  [15:0]          MemDB
);

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, RD_DRIVE, WR_WAIT, WR_HOLD
  } state_t;

  localparam logic [2:0] RD_LAST = 3'(RD_LAT - 1);
  localparam logic [2:0] WR_LAST = 3'(WR_LAT - 1);

  state_t              state, nxt;
  logic [2:0]          cnt, cnt_n;
  logic [ADDR_W-1:0]   a_lat, alat_n;
  logic                perr, perr_n;
  logic                rd_done, wr_done;
  logic                commit;
  logic                cs_q, oe_q, wr_q, lb_q, ub_q;
  logic [ADDR_W-1:0]   adr_q;
  logic                drv_lo, drv_hi;
  logic [15:0]         rdata;
  logic [15:0]         mem [2**ADDR_W];
  logic                unused;

  assign unused = ^{bus.RamAdv, bus.RamClk,
                    bus.MemAdr[22:ADDR_W]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_q  <= 1'b1;
      oe_q  <= 1'b1;
      wr_q  <= 1'b1;
      lb_q  <= 1'b1;
      ub_q  <= 1'b1;
      adr_q <= '0;
    end else begin
      cs_q  <= bus.RamCS;
      oe_q  <= bus.MemOE;
      wr_q  <= bus.MemWR;
      lb_q  <= bus.RamLB;
      ub_q  <= bus.RamUB;
      adr_q <= bus.MemAdr[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      a_lat   <= '0;
      perr    <= 1'b0;
      rd_done <= 1'b0;
      wr_done <= 1'b0;
    end else begin
      state   <= nxt;
      cnt     <= cnt_n;
      a_lat   <= alat_n;
      perr    <= perr_n;
      rd_done <= (nxt == RD_DRIVE) && (state != RD_DRIVE);
      wr_done <= commit;
    end
  end

  always_comb begin
    nxt    = state;
    cnt_n  = cnt;
    alat_n = a_lat;
    perr_n = perr;
    commit = 1'b0;
    case (state)
      IDLE: begin
        if (!cs_q && !wr_q) begin
          nxt    = WR_WAIT;
          alat_n = adr_q;
          cnt_n  = '0;
          if (!oe_q) perr_n = 1'b1;
        end else if (!cs_q && !oe_q) begin
          nxt    = RD_WAIT;
          alat_n = adr_q;
          cnt_n  = '0;
        end
      end
      RD_WAIT: begin
        if (cs_q || oe_q) begin
          nxt = IDLE;
        end else if (adr_q != a_lat) begin
          alat_n = adr_q;
          cnt_n  = '0;
        end else if (cnt == RD_LAST) begin
          nxt = RD_DRIVE;
        end else begin
          cnt_n = cnt + 3'd1;
        end
      end
      RD_DRIVE: begin
        if (cs_q || oe_q) begin
          nxt = IDLE;
        end else if (!wr_q) begin
          nxt    = WR_WAIT;
          perr_n = 1'b1;
          alat_n = adr_q;
          cnt_n  = '0;
        end else if (adr_q != a_lat) begin
          nxt    = RD_WAIT;
          alat_n = adr_q;
          cnt_n  = '0;
        end
      end
      WR_WAIT: begin
        if (cs_q || wr_q) begin
          nxt = IDLE;
        end else if (adr_q != a_lat) begin
          alat_n = adr_q;
          cnt_n  = '0;
        end else if (cnt == WR_LAST) begin
          nxt    = WR_HOLD;
          commit = 1'b1;
        end else begin
          cnt_n = cnt + 3'd1;
        end
      end
      WR_HOLD: begin
        if (cs_q || wr_q) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    drv_lo = (state == RD_DRIVE) && !lb_q;
    drv_hi = (state == RD_DRIVE) && !ub_q;
    rdata  = mem[a_lat];
  end

  // No reset on the array: contents survive rst_n.
  always_ff @(posedge clk) begin
    if (commit) begin
      if (!lb_q) mem[a_lat][7:0]  <= MemDB[7:0];
      if (!ub_q) mem[a_lat][15:8] <= MemDB[15:8];
    end
  end

  assign MemDB[7:0]  = drv_lo ? rdata[7:0]  : 8'hzz;
  assign MemDB[15:8] = drv_hi ? rdata[15:8] : 8'hzz;

  assign bus.busy      = (state != IDLE);
  assign bus.rd_done   = rd_done;
  assign bus.wr_done   = wr_done;
  assign bus.proto_err = perr;

endmodule
